// File: rtl/jt89_gg_pan_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : jt89_gg_pan_ctrl_if
//  Description : Bus bundle between the Game Gear stereo register writer and
//                the pan fade controller (write strobe, data, fade step
//                enable, and the pan / fade weight / status results).
//  Revision    : 1.0 - initial release
// ============================================================================
interface jt89_gg_pan_ctrl_if;
    logic       cen_16;
    logic       wr;
    logic [7:0] din;
    logic [7:0] pan;
    logic [3:0] vol;
    logic       busy;
    logic [7:0] dout;

    // Writer / host side
    modport master (
        output cen_16,
        output wr,
        output din,
        input  pan,
        input  vol,
        input  busy,
        input  dout
    );

    // Pan controller side
    modport slave (
        input  cen_16,
        input  wr,
        input  din,
        output pan,
        output vol,
        output busy,
        output dout
    );
endinterface
`default_nettype wire

// File: rtl/jt89_gg_pan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : jt89_gg_pan_ctrl
//  Description : Game Gear stereo (port 0x06) pan controller. With the
//                JT89_PAN_FADE_EN macro defined, a pan change fades the
//                output weight down to silence, swaps the pan word, then
//                fades back up, so no channel ever jumps in or out at level.
//                Without the macro, writes are applied directly.
//  Revision    : 1.0 - initial release
// ============================================================================
module jt89_gg_pan_ctrl (
    input  wire                  clk,
    input  wire                  rst,    // synchronous, active-low
    jt89_gg_pan_ctrl_if.slave    bus
);

    localparam logic [7:0] c_PAN_RESET = 8'hFF;
    localparam logic [3:0] c_VOL_MAX   = 4'hF;
    localparam logic [3:0] c_VOL_MIN   = 4'h0;

    wire       w_wr  = bus.wr;
    wire [7:0] w_din = bus.din;

    logic [7:0] r_pan;
    logic [7:0] r_pend;

`ifdef JT89_PAN_FADE_EN

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FADE_OUT = 2'd1,
        ST_SWAP     = 2'd2,
        ST_FADE_IN  = 2'd3
    } state_t;

    state_t     r_state;
    logic [3:0] r_vol;
    logic       r_busy;

    wire w_cen      = bus.cen_16;
    wire w_wr_diff  = w_wr && (w_din != r_pan);

    // Fade state machine: pending register, fade weight, pan swap and busy flag
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_pan   <= c_PAN_RESET;
            r_pend  <= c_PAN_RESET;
            r_vol   <= c_VOL_MAX;
            r_busy  <= 1'b0;
        end else begin
            // Every write lands in the pending register, whatever the state
            if (w_wr) begin
                r_pend <= w_din;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_wr_diff) begin
                        r_state <= ST_FADE_OUT;
                        r_busy  <= 1'b1;
                    end
                end

                ST_FADE_OUT: begin
                    // Writes here only refresh pend; the swap picks up the latest
                    if (w_cen) begin
                        if (r_vol == c_VOL_MIN) begin
                            r_state <= ST_SWAP;
                        end else begin
                            r_vol <= r_vol - 4'd1;
                        end
                    end
                end

                ST_SWAP: begin
                    // A write arriving on the swap clock itself is the newest value
                    r_pan   <= w_wr ? w_din : r_pend;
                    r_state <= ST_FADE_IN;
                end

                ST_FADE_IN: begin
                    if (w_cen && (r_vol != c_VOL_MAX)) begin
                        r_vol <= r_vol + 4'd1;
                    end
                    // A new differing write reverses direction from the current level
                    if (w_wr_diff) begin
                        r_state <= ST_FADE_OUT;
                    end else if (w_cen && (r_vol == c_VOL_MAX)) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.vol  = r_vol;
    assign bus.busy = r_busy;

`else

    // The fade step enable has no consumer when the fade is compiled out
    wire w_unused_cen = bus.cen_16;

    // Direct path: each write goes straight to both pan and pend
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pan  <= c_PAN_RESET;
            r_pend <= c_PAN_RESET;
        end else if (w_wr) begin
            r_pan  <= w_din;
            r_pend <= w_din;
        end
    end

    assign bus.vol  = c_VOL_MAX;
    assign bus.busy = 1'b0;

`endif

    assign bus.pan  = r_pan;
    assign bus.dout = r_pend;

endmodule
`default_nettype wire

// File: tb/tb_jt89_gg_pan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_jt89_gg_pan_ctrl
//  Description : Directed self-checking bench for jt89_gg_pan_ctrl. Covers
//                the direct-write build by default and the fade sequence
//                when JT89_PAN_FADE_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_jt89_gg_pan_ctrl;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    jt89_gg_pan_ctrl_if u_if ();

    jt89_gg_pan_ctrl u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic write(input logic [7:0] d);
        u_if.wr  = 1'b1;
        u_if.din = d;
        tick();
        u_if.wr  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick(2);
        rst = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst      = 1'b0;
        u_if.wr  = 1'b1;      // writes during reset must be ignored
        u_if.din = 8'h12;
        tick(3);
        u_if.wr  = 1'b0;
        rst      = 1'b1;
        tick(2);
        n_cmp++; if (u_if.pan !== 8'hFF) begin n_bad++; $display("FAIL reset_pan got %h want FF", u_if.pan); end
        n_cmp++; if (u_if.vol !== 4'hF) begin n_bad++; $display("FAIL reset_vol got %h want F", u_if.vol); end
        n_cmp++; if (u_if.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", u_if.busy); end
        n_cmp++; if (u_if.dout !== 8'hFF) begin n_bad++; $display("FAIL reset_dout got %h want FF", u_if.dout); end
    endtask

`ifndef JT89_PAN_FADE_EN

    task automatic test_direct_write();
        write(8'hA5);
        n_cmp++; if (u_if.pan !== 8'hA5) begin n_bad++; $display("FAIL direct_pan got %h want A5", u_if.pan); end
        n_cmp++; if (u_if.dout !== 8'hA5) begin n_bad++; $display("FAIL direct_dout got %h want A5", u_if.dout); end
        n_cmp++; if (u_if.vol !== 4'hF) begin n_bad++; $display("FAIL direct_vol got %h want F", u_if.vol); end
        n_cmp++; if (u_if.busy !== 1'b0) begin n_bad++; $display("FAIL direct_busy got %b want 0", u_if.busy); end
    endtask

    task automatic test_back_to_back();
        u_if.wr  = 1'b1;
        u_if.din = 8'h3C;
        tick();
        n_cmp++; if (u_if.pan !== 8'h3C) begin n_bad++; $display("FAIL b2b_pan1 got %h want 3C", u_if.pan); end
        u_if.din = 8'hC3;
        tick();
        u_if.wr  = 1'b0;
        n_cmp++; if (u_if.pan !== 8'hC3) begin n_bad++; $display("FAIL b2b_pan2 got %h want C3", u_if.pan); end
        n_cmp++; if (u_if.dout !== 8'hC3) begin n_bad++; $display("FAIL b2b_dout got %h want C3", u_if.dout); end
        u_if.din = 8'h00;     // data change without strobe must not load
        tick(2);
        n_cmp++; if (u_if.pan !== 8'hC3) begin n_bad++; $display("FAIL nostrobe_pan got %h want C3", u_if.pan); end
    endtask

    task automatic test_cen_ignored();
        for (int i = 0; i < 20; i++) begin
            u_if.cen_16 = 1'b1;
            tick();
            u_if.cen_16 = 1'b0;
            tick();
        end
        n_cmp++; if (u_if.vol !== 4'hF) begin n_bad++; $display("FAIL cen_vol got %h want F", u_if.vol); end
        n_cmp++; if (u_if.busy !== 1'b0) begin n_bad++; $display("FAIL cen_busy got %b want 0", u_if.busy); end
        n_cmp++; if (u_if.pan !== 8'hC3) begin n_bad++; $display("FAIL cen_pan got %h want C3", u_if.pan); end
    endtask

    task automatic test_reset_mid();
        write(8'h5A);
        rst      = 1'b0;
        u_if.wr  = 1'b1;
        u_if.din = 8'h77;
        tick();
        n_cmp++; if (u_if.pan !== 8'hFF) begin n_bad++; $display("FAIL rstmid_pan got %h want FF", u_if.pan); end
        n_cmp++; if (u_if.dout !== 8'hFF) begin n_bad++; $display("FAIL rstmid_dout got %h want FF", u_if.dout); end
        u_if.wr = 1'b0;
        rst     = 1'b1;
        tick();
        n_cmp++; if (u_if.pan !== 8'hFF) begin n_bad++; $display("FAIL rstrel_pan got %h want FF", u_if.pan); end
        n_cmp++; if (u_if.vol !== 4'hF) begin n_bad++; $display("FAIL rstrel_vol got %h want F", u_if.vol); end
    endtask

`else

    // One fade step: a single cen_16 pulse followed by three idle clocks
    task automatic pulse(input int n = 1);
        for (int i = 0; i < n; i++) begin
            u_if.cen_16 = 1'b1;
            tick();
            u_if.cen_16 = 1'b0;
            tick(3);
        end
    endtask

    task automatic test_fade_full();
        write(8'h0F);
        n_cmp++; if (u_if.busy !== 1'b1) begin n_bad++; $display("FAIL full_busy_start got %b want 1", u_if.busy); end
        n_cmp++; if (u_if.vol !== 4'hF) begin n_bad++; $display("FAIL full_vol_start got %h want F", u_if.vol); end
        pulse(8);
        n_cmp++; if (u_if.vol !== 4'h7) begin n_bad++; $display("FAIL full_vol_mid got %h want 7", u_if.vol); end
        n_cmp++; if (u_if.pan !== 8'hFF) begin n_bad++; $display("FAIL full_pan_hold got %h want FF", u_if.pan); end
        pulse(7);
        n_cmp++; if (u_if.vol !== 4'h0) begin n_bad++; $display("FAIL full_vol_zero got %h want 0", u_if.vol); end
        n_cmp++; if (u_if.pan !== 8'hFF) begin n_bad++; $display("FAIL full_pan_pre got %h want FF", u_if.pan); end
        pulse(1);
        n_cmp++; if (u_if.pan !== 8'h0F) begin n_bad++; $display("FAIL full_pan_swap got %h want 0F", u_if.pan); end
        n_cmp++; if (u_if.vol !== 4'h0) begin n_bad++; $display("FAIL full_vol_floor got %h want 0", u_if.vol); end
        pulse(15);
        n_cmp++; if (u_if.vol !== 4'hF) begin n_bad++; $display("FAIL full_vol_top got %h want F", u_if.vol); end
        n_cmp++; if (u_if.busy !== 1'b1) begin n_bad++; $display("FAIL full_busy_top got %b want 1", u_if.busy); end
        pulse(1);
        n_cmp++; if (u_if.busy !== 1'b0) begin n_bad++; $display("FAIL full_busy_end got %b want 0", u_if.busy); end
        n_cmp++; if (u_if.vol !== 4'hF) begin n_bad++; $display("FAIL full_vol_end got %h want F", u_if.vol); end
    endtask

    task automatic test_last_wins();
        logic seen_0f;
        do_reset();
        seen_0f = 1'b0;
        write(8'h0F);
        pulse(3);
        write(8'hF0);
        for (int i = 0; i < 13; i++) begin
            pulse(1);
            if (u_if.pan == 8'h0F) seen_0f = 1'b1;
        end
        n_cmp++; if (u_if.dout !== 8'hF0) begin n_bad++; $display("FAIL lw_dout got %h want F0", u_if.dout); end
        n_cmp++; if (u_if.pan !== 8'hF0) begin n_bad++; $display("FAIL lw_pan got %h want F0", u_if.pan); end
        n_cmp++; if (seen_0f !== 1'b0) begin n_bad++; $display("FAIL lw_no0f got %b want 0", seen_0f); end
        pulse(16);
        n_cmp++; if (u_if.busy !== 1'b0) begin n_bad++; $display("FAIL lw_busy got %b want 0", u_if.busy); end
    endtask

    task automatic test_fade_in_redirect();
        write(8'h0F);          // pan is F0 from the previous scenario
        pulse(16);
        pulse(6);
        n_cmp++; if (u_if.vol !== 4'h6) begin n_bad++; $display("FAIL rd_vol6 got %h want 6", u_if.vol); end
        write(8'h33);
        n_cmp++; if (u_if.vol !== 4'h6) begin n_bad++; $display("FAIL rd_vol_keep got %h want 6", u_if.vol); end
        pulse(1);
        n_cmp++; if (u_if.vol !== 4'h5) begin n_bad++; $display("FAIL rd_vol_down got %h want 5", u_if.vol); end
        pulse(5);
        n_cmp++; if (u_if.pan !== 8'h0F) begin n_bad++; $display("FAIL rd_pan_hold got %h want 0F", u_if.pan); end
        pulse(1);
        n_cmp++; if (u_if.pan !== 8'h33) begin n_bad++; $display("FAIL rd_pan_swap got %h want 33", u_if.pan); end
        pulse(16);
        n_cmp++; if (u_if.busy !== 1'b0) begin n_bad++; $display("FAIL rd_busy got %b want 0", u_if.busy); end
    endtask

    task automatic test_same_value();
        do_reset();
        write(8'hFF);
        pulse(2);
        n_cmp++; if (u_if.busy !== 1'b0) begin n_bad++; $display("FAIL same_busy got %b want 0", u_if.busy); end
        n_cmp++; if (u_if.vol !== 4'hF) begin n_bad++; $display("FAIL same_vol got %h want F", u_if.vol); end
        n_cmp++; if (u_if.dout !== 8'hFF) begin n_bad++; $display("FAIL same_dout got %h want FF", u_if.dout); end
    endtask

    task automatic test_reset_mid();
        write(8'h0F);
        pulse(12);
        n_cmp++; if (u_if.vol !== 4'h3) begin n_bad++; $display("FAIL rstmid_vol3 got %h want 3", u_if.vol); end
        rst = 1'b0;
        tick();
        rst = 1'b1;
        n_cmp++; if (u_if.pan !== 8'hFF) begin n_bad++; $display("FAIL rstmid_pan got %h want FF", u_if.pan); end
        n_cmp++; if (u_if.vol !== 4'hF) begin n_bad++; $display("FAIL rstmid_vol got %h want F", u_if.vol); end
        n_cmp++; if (u_if.busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy got %b want 0", u_if.busy); end
        n_cmp++; if (u_if.dout !== 8'hFF) begin n_bad++; $display("FAIL rstmid_dout got %h want FF", u_if.dout); end
    endtask

`endif

    initial begin
        n_cmp       = 0;
        n_bad       = 0;
        rst         = 1'b0;
        u_if.wr     = 1'b0;
        u_if.din    = 8'h00;
        u_if.cen_16 = 1'b0;

        test_reset();
`ifndef JT89_PAN_FADE_EN
        test_direct_write();
        test_back_to_back();
        test_cen_ignored();
        test_reset_mid();
`else
        test_fade_full();
        test_last_wins();
        test_fade_in_redirect();
        test_same_value();
        test_reset_mid();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/jt89_gg_pan_ctrl.md
JT89_GG_PAN_CTRL -- requirements
Module: jt89_gg_pan_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: system clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous, active-low.
REQ-003 SHALL have port cen_16, input, 1 bit: fade step enable; one-clk pulse, same cadence as the mixer's 16x sample enable.
REQ-004 SHALL have port wr, input, 1 bit: one-clk write strobe for the Game Gear stereo register (port 0x06).
REQ-005 SHALL have port din, input, 8 bits: write data; bits 7:4 left enables for noise, ch2, ch1, ch0; bits 3:0 right enables in the same order.
REQ-006 SHALL have port pan, output, 8 bits: applied pan word, driven straight to the mixer pan input.
REQ-007 SHALL have port vol, output, 4 bits: unsigned fade weight, 15 = full level, 0 = silent; consumed by the downstream scaler.
REQ-008 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-009 SHALL have port dout, output, 8 bits: readback of the pending register (last value written).

Function
REQ-010 SHALL hold a pending register pend; every wr loads din into pend in the same clk, in any state.
REQ-011 SHALL implement states IDLE, FADE_OUT, SWAP and FADE_IN.
REQ-012 In IDLE, wr with din != pan SHALL move the state to FADE_OUT on the next clk; wr with din == pan SHALL leave the state in IDLE.
REQ-013 In FADE_OUT, on each cen_16: if vol == 0, go to SWAP; otherwise decrement vol by 1.
REQ-014 SWAP SHALL last exactly one clk, independent of cen_16; it loads pan <= (wr ? din : pend) and then moves to FADE_IN.
REQ-015 In FADE_IN, on each cen_16: if vol == 15, go to IDLE; otherwise increment vol by 1.
REQ-016 In FADE_IN, wr with din != pan SHALL move the state to FADE_OUT, keeping the current vol (no jump).
REQ-017 wr in FADE_OUT or SWAP SHALL only update pend; the state sequence continues unchanged (last write wins).
REQ-018 vol SHALL saturate within 0..15; it SHALL never wrap.
REQ-019 wr and cen_16 in the same clk SHALL both take effect: the pend update and the vol/state step occur together.
REQ-020 pan SHALL change only in SWAP, so it never changes while vol != 0.
REQ-021 From IDLE with vol = 15, a full transition SHALL take 16 cen_16 pulses in FADE_OUT, 1 SWAP clk, then 16 cen_16 pulses in FADE_IN.

Reset
REQ-022 While rst = 0 at a clk edge: pan = 8'hFF, pend = 8'hFF, vol = 15, state = IDLE, busy = 0, dout = 8'hFF.
REQ-023 Reset mid-fade SHALL abort the sequence; the pending write is discarded and all values return to REQ-022 values.
REQ-024 wr SHALL be ignored while rst = 0.

Configuration
REQ-025 Macro JT89_PAN_FADE_EN SHALL control the fade feature.
REQ-026 With JT89_PAN_FADE_EN defined, the fade state machine SHALL operate as in REQ-010..REQ-021.
REQ-027 With JT89_PAN_FADE_EN undefined: wr loads pan and pend on the next clk; vol is held at 15; busy is held at 0; no fade state machine is present.

Verification
REQ-028 Reset release, no writes -> pan = FF, vol = 15, busy = 0, dout = FF.
REQ-029 Write 8'h0F in IDLE, cen_16 every 4 clk:
- vol steps 15 down to 0;
- pan = 0F after 16 cen_16 pulses plus 1 clk;
- vol steps back up to 15;
- busy falls after the 16th FADE_IN cen_16.
REQ-030 Write 8'h0F, then 8'hF0 during FADE_OUT -> a single SWAP loads pan = F0; pan never takes the value 0F.
REQ-031 Write 8'h33 during FADE_IN at vol = 6 -> state goes to FADE_OUT from vol = 6, then SWAP to pan = 33.
REQ-032 Write 8'hFF in IDLE with pan = FF -> busy stays 0, vol stays 15, dout = FF.
REQ-033 Assert rst = 0 during FADE_OUT at vol = 3 -> the next clk shows pan = FF, vol = 15, busy = 0.
REQ-034 Build without JT89_PAN_FADE_EN, write 8'hA5 -> pan = A5 one clk later; vol = 15 and busy = 0 throughout.
